bf16_acc_seq: RTL and testbench
===============================

# bf16_acc_seq

Sequencing controller that reduces a stream of bf16 operands to a single bf16 sum by repeatedly driving one combinational `bf16_add` instance with a running accumulator. It accepts one operand per cycle over a valid/ready input, closes a vector on `i_last`, and presents the registered sum with its class flags on a valid/ready output. It sits between the KAN spline-evaluation lanes and the layer output buffer, and performs the per-neuron summation.

## Interface
- `CNT_WIDTH`, 8, width of beat counter `o_count`
- `i_clk`  input  1  clock, rising edge
- `i_rst_n`  input  1  reset, asynchronous, active-low
- `i_clear`  input  1  synchronous abort: drop vector/result, return to IDLE
- `i_valid`  input  1  operand valid
- `o_ready`  output  1  operand accepted when `i_valid & o_ready`
- `i_data`  input  16  bf16 operand
- `i_last`  input  1  qualifies final operand of vector
- `o_valid`  output  1  result valid
- `i_ready`  input  1  result consumed when `o_valid & i_ready`
- `o_data`  output  16  bf16 sum
- `o_flag`  output  4  one-hot class of `o_data`: [3] NaN, [2] zero, [1] inf, [0] normal
- `o_count`  output  CNT_WIDTH  beats accumulated in current/last vector, saturating
- `o_busy`  output  1  high in ACC or DONE

## Operation
- Internal `bf16_add` operands: a = accumulator `acc`, b = `i_data` (b-side NaN propagates first).
- States: IDLE, ACC, DONE.
  - IDLE: `acc` = 0x0000. Beat & !last -> ACC, `acc` <= sum, count <= 1. Beat & last -> DONE.
  - ACC: beat & !last -> `acc` <= sum, count++. Beat & last -> DONE.
  - DONE: `o_valid`=1; `o_data`/`o_flag`/`o_count` frozen. `i_ready` -> IDLE, `acc` cleared.
- Entering DONE: `o_data` <= sum of `acc` + final operand; `o_count` <= count+1.
- `o_flag` classification of `o_data`: exp=0xFF & mant!=0 -> NaN; exp=0xFF & mant=0 -> inf; exp=0 -> zero; else normal. Block-computed, not taken from adder flag output.
- Count saturates at 2^CNT_WIDTH-1; accumulation continues past saturation.
- `i_clear` has priority over all: next state IDLE, `acc`=0, `o_valid`=0, count=0, sticky bits cleared; a coincident beat or output handshake is discarded.
- Empty vectors impossible: every vector holds >=1 beat.

## Timing
- Reset values: `o_ready`=1, `o_valid`=0, `o_data`=0x0000, `o_flag`=4'b0000, `o_count`=0, `o_busy`=0, state IDLE.
- `o_ready` = (state != DONE), registered-state decode, no combinational path from `i_valid` or `i_ready`.
- Throughput: one operand per cycle in IDLE/ACC.
- Latency: last beat accepted at edge N -> `o_valid` high after edge N; consumed at edge M -> `o_ready` high after M, next vector's first beat accepted at M+1 earliest (one bubble per vector).
- `o_data`, `o_flag`, `o_count` stable while `o_valid & !i_ready`.
- Reset assertion mid-vector: immediate return to reset values; partial sum lost.

## Configuration
- `BF16_ACC_STICKY_EN` defined: sticky NaN and inf bits set whenever any intermediate sum in the vector classifies NaN/inf; on entering DONE they are ORed into `o_flag[3]`/`o_flag[1]` (`o_flag` may then be non-one-hot). Cleared on entering IDLE.
- Not defined: no sticky logic; `o_flag` strictly one-hot classification of final `o_data`.

## Test plan
- 0x3F80, 0x4000, 0x4040(last), `i_ready`=1 -> `o_data`=0x40C0, `o_flag`=0001, `o_count`=3, `o_valid` one cycle after last beat.
- Single beat 0x3F80(last) -> `o_data`=0x3F80, `o_flag`=0001, `o_count`=1.
- 0x3F80, 0xBF80(last) -> `o_data`=0x0000, `o_flag`=0100.
- 0x7F80, 0xFF80(last) -> `o_data`=0xFFC0; `o_flag`=1010 with `BF16_ACC_STICKY_EN`, 1000 without.
- Result backpressure: `i_ready` low 3 cycles, `i_valid` held high -> `o_ready`=0, no beat accepted, outputs stable; `i_ready` high -> IDLE next cycle, beat accepted following cycle.
- `i_clear` after 2 of 4 beats, then 0x4000(last) -> `o_data`=0x4000, `o_count`=1; async reset mid-vector -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bf16_acc_seq_if.sv
// Handshake bundle for bf16_acc_seq: operand input channel, result output channel and status.
interface bf16_acc_seq_if #(
   parameter int CNT_WIDTH = 8
) ();
   logic                 i_clear;
   logic                 i_valid;
   logic                 o_ready;
   logic [15:0]          i_data;
   logic                 i_last;
   logic                 o_valid;
   logic                 i_ready;
   logic [15:0]          o_data;
   logic [3:0]           o_flag;
   logic [CNT_WIDTH-1:0] o_count;
   logic                 o_busy;

   modport master (
      output i_clear, i_valid, i_data, i_last, i_ready,
      input  o_ready, o_valid, o_data, o_flag, o_count, o_busy
   );

   modport slave (
      input  i_clear, i_valid, i_data, i_last, i_ready,
      output o_ready, o_valid, o_data, o_flag, o_count, o_busy
   );
endinterface

// File: rtl/bf16_acc_seq.sv
// bf16 stream accumulator: folds operands through one combinational bf16 adder into a registered sum.
// Optional macro BF16_ACC_STICKY_EN ORs sticky NaN/inf history of the vector into the result flags.

module bf16_add (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o
);
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
   logic        [15:0] big, sml;
   logic        [7:0]  ediff;
   logic        [10:0] big_m, sml_m, sml_sh;
   logic        [11:0] mag;
   logic        [10:0] norm;
   logic        [3:0]  lz;
   logic signed [9:0]  exp_w;
   logic        [8:0]  rnd;
   logic               round_up;

   function automatic logic [3:0] lzc11(input logic [10:0] v);
      lzc11 = 4'd0;
      for (int i = 0; i <= 10; i++) begin
         if (v[i]) lzc11 = 4'(10 - i);
      end
   endfunction

   // Subnormal inputs are treated as zero and underflowing results flush to signed zero.
   always_comb begin
      a_nan  = (a_i[14:7] == 8'hFF) && (a_i[6:0] != 7'd0);
      b_nan  = (b_i[14:7] == 8'hFF) && (b_i[6:0] != 7'd0);
      a_inf  = (a_i[14:7] == 8'hFF) && (a_i[6:0] == 7'd0);
      b_inf  = (b_i[14:7] == 8'hFF) && (b_i[6:0] == 7'd0);
      a_zero = (a_i[14:7] == 8'h00);
      b_zero = (b_i[14:7] == 8'h00);

      swap  = (b_i[14:0] > a_i[14:0]);
      big   = swap ? b_i : a_i;
      sml   = swap ? a_i : b_i;
      ediff = big[14:7] - sml[14:7];
      big_m = {1'b1, big[6:0], 3'b000};
      sml_m = {1'b1, sml[6:0], 3'b000};

      // Bits shifted out of the smaller operand collapse into a sticky LSB.
      if (ediff >= 8'd11) begin
         sml_sh = 11'd1;
      end else begin
         sml_sh    = sml_m >> ediff[3:0];
         sml_sh[0] = sml_sh[0] | (|(sml_m & ~(11'h7FF << ediff[3:0])));
      end

      mag   = '0;
      norm  = '0;
      lz    = '0;
      exp_w = '0;
      if (big[15] == sml[15]) begin
         mag = {1'b0, big_m} + {1'b0, sml_sh};
         if (mag[11]) begin
            norm  = {mag[11:2], mag[1] | mag[0]};
            exp_w = 10'(big[14:7]) + 10'sd1;
         end else begin
            norm  = mag[10:0];
            exp_w = 10'(big[14:7]);
         end
      end else begin
         mag   = {1'b0, big_m} - {1'b0, sml_sh};
         lz    = lzc11(mag[10:0]);
         norm  = mag[10:0] << lz;
         exp_w = 10'(big[14:7]) - 10'(lz);
      end

      // Round to nearest, ties to even, on guard bit plus sticky.
      round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
      rnd      = {1'b0, norm[10:3]} + 9'(round_up);
      if (rnd[8]) exp_w = exp_w + 10'sd1;

      if (b_nan)                                  sum_o = b_i | 16'h0040;
      else if (a_nan)                             sum_o = a_i | 16'h0040;
      else if (a_inf && b_inf && (a_i[15] != b_i[15])) sum_o = 16'hFFC0;
      else if (a_inf)                             sum_o = a_i;
      else if (b_inf)                             sum_o = b_i;
      else if (a_zero && b_zero)                  sum_o = {a_i[15] & b_i[15], 15'd0};
      else if (a_zero)                            sum_o = b_i;
      else if (b_zero)                            sum_o = a_i;
      else if (mag == 12'd0)                      sum_o = 16'h0000;
      else if (exp_w >= 10'sd255)                 sum_o = {big[15], 8'hFF, 7'd0};
      else if (exp_w <= 10'sd0)                   sum_o = {big[15], 15'd0};
      else                                        sum_o = {big[15], exp_w[7:0], rnd[6:0]};
   end
endmodule

module bf16_acc_seq #(
   parameter int CNT_WIDTH = 8
) (
   input logic           i_clk,
   input logic           i_rst_n,
   bf16_acc_seq_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_e;

   state_e               state_q, state_d;
   logic [15:0]          acc_q, acc_d, data_q, data_d, sum;
   logic [3:0]           flag_q, flag_d, sum_cls, sticky_mask;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
   logic                 beat;

   function automatic logic [3:0] classify(input logic [15:0] v);
      if (v[14:7] == 8'hFF)      classify = (v[6:0] != 7'd0) ? 4'b1000 : 4'b0010;
      else if (v[14:7] == 8'h00) classify = 4'b0100;
      else                       classify = 4'b0001;
   endfunction

   bf16_add u_add (
      .a_i   (acc_q),
      .b_i   (bus.i_data),
      .sum_o (sum)
   );

   assign beat    = bus.i_valid && (state_q != ST_DONE);
   assign sum_cls = classify(sum);
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef BF16_ACC_STICKY_EN
   logic sticky_nan_q, sticky_nan_d, sticky_inf_q, sticky_inf_d;

   always_comb begin
      sticky_nan_d = sticky_nan_q;
      sticky_inf_d = sticky_inf_q;
      if (bus.i_clear || ((state_q == ST_DONE) && bus.i_ready)) begin
         sticky_nan_d = 1'b0;
         sticky_inf_d = 1'b0;
      end else if (beat) begin
         sticky_nan_d = sticky_nan_q | sum_cls[3];
         sticky_inf_d = sticky_inf_q | sum_cls[1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sticky_nan_q <= 1'b0;
         sticky_inf_q <= 1'b0;
      end else begin
         sticky_nan_q <= sticky_nan_d;
         sticky_inf_q <= sticky_inf_d;
      end
   end

   assign sticky_mask = {sticky_nan_q, 1'b0, sticky_inf_q, 1'b0};
`else
   assign sticky_mask = 4'b0000;
`endif

   // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      data_d  = data_q;
      flag_d  = flag_q;
      cnt_d   = cnt_q;
      if (bus.i_clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         data_d  = '0;
         flag_d  = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ACC: begin
               if (beat) begin
                  cnt_d = (state_q == ST_IDLE) ? CNT_WIDTH'(1) : cnt_inc;
                  if (bus.i_last) begin
                     state_d = ST_DONE;
                     data_d  = sum;
                     flag_d  = sum_cls | sticky_mask;
                  end else begin
                     state_d = ST_ACC;
                     acc_d   = sum;
                  end
               end
            end
            ST_DONE: begin
               if (bus.i_ready) begin
                  state_d = ST_IDLE;
                  acc_d   = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         data_q  <= '0;
         flag_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_ready = (state_q != ST_DONE);
   assign bus.o_valid = (state_q == ST_DONE);
   assign bus.o_busy  = (state_q != ST_IDLE);
   assign bus.o_data  = data_q;
   assign bus.o_flag  = flag_q;
   assign bus.o_count = cnt_q;
endmodule

// File: tb/tb_bf16_acc_seq.sv
// Self-checking bench for bf16_acc_seq: directed scenarios plus random vectors against a real-valued model.
module tb_bf16_acc_seq;
   localparam int CW = 8;

`ifdef BF16_ACC_STICKY_EN
   localparam logic [3:0] INF_NAN_FLAG = 4'b1010;
   localparam bit         STICKY       = 1'b1;
`else
   localparam logic [3:0] INF_NAN_FLAG = 4'b1000;
   localparam bit         STICKY       = 1'b0;
`endif

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   bf16_acc_seq_if #(.CNT_WIDTH(CW)) bus ();

   bf16_acc_seq #(.CNT_WIDTH(CW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [15:0] vec[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model: bf16 values as reals ----------------
   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic bit is_nan(input logic [15:0] v);
      return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
   endfunction

   function automatic bit is_inf(input logic [15:0] v);
      return (v[14:7] == 8'hFF) && (v[6:0] == 7'd0);
   endfunction

   function automatic real bf_val(input logic [15:0] v);
      real m;
      if (v[14:7] == 8'h00) return 0.0;
      m = (128.0 + real'(v[6:0])) * pow2(int'(v[14:7]) - 134);
      return v[15] ? -m : m;
   endfunction

   function automatic logic [15:0] real_to_bf16(input real x);
      logic s = (x < 0.0);
      real  m = s ? -x : x;
      int   e = 0;
      real  q, fr;
      int   i;
      while (m >= pow2(e + 1)) e++;
      while (m < pow2(e)) e--;
      q  = m / pow2(e - 7);
      i  = $rtoi(q);
      fr = q - real'(i);
      if ((fr > 0.5) || ((fr == 0.5) && (i % 2 == 1))) i++;
      if (i == 256) begin
         i = 128;
         e++;
      end
      if (e > 127)  return {s, 8'hFF, 7'h00};
      if (e < -126) return {s, 15'h0000};
      return {s, 8'(e + 127), 7'(i - 128)};
   endfunction

   function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
      real s;
      if (is_nan(b)) return b | 16'h0040;
      if (is_nan(a)) return a | 16'h0040;
      if (is_inf(a) && is_inf(b)) return (a == b) ? a : 16'hFFC0;
      if (is_inf(a)) return a;
      if (is_inf(b)) return b;
      if ((a[14:7] == 8'h00) && (b[14:7] == 8'h00)) return {a[15] & b[15], 15'h0000};
      s = bf_val(a) + bf_val(b);
      if (s == 0.0) return 16'h0000;
      return real_to_bf16(s);
   endfunction

   function automatic logic [3:0] class_of(input logic [15:0] v);
      if (is_nan(v))            return 4'b1000;
      if (is_inf(v))            return 4'b0010;
      if (v[14:7] == 8'h00)     return 4'b0100;
      return 4'b0001;
   endfunction

   task automatic model_vec(output logic [15:0] d, output logic [3:0] f, output int n);
      logic [15:0] acc  = 16'h0000;
      logic [3:0]  seen = 4'b0000;
      foreach (vec[i]) begin
         acc  = ref_add(acc, vec[i]);
         seen = seen | (class_of(acc) & 4'b1010);
      end
      d = acc;
      f = STICKY ? (class_of(acc) | seen) : class_of(acc);
      n = (vec.size() > 255) ? 255 : vec.size();
   endtask

   function automatic logic [15:0] rand_bf16();
      logic       s = 1'($urandom_range(0, 1));
      logic [6:0] f = 7'($urandom);
      case ($urandom_range(0, 31))
         0:       return {s, 8'hFF, 7'h00};
         1:       return {s, 8'hFF, 7'($urandom_range(1, 127))};
         2, 3:    return {s, 8'h00, f};
         4, 5:    return {s, 8'($urandom_range(248, 254)), f};
         6, 7:    return {s, 8'($urandom_range(1, 8)), f};
         default: return {s, 8'($urandom_range(122, 132)), f};
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic wait_ready(input string tag);
      int guard = 0;
      while ((bus.o_ready !== 1'b1) && (guard < 20)) begin
         @(posedge i_clk); #1;
         guard++;
      end
      if (guard >= 20) check({tag, "/ready_timeout"}, 32'(bus.o_ready), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/o_ready"}, 32'(bus.o_ready), 32'd1);
      check({tag, "/o_valid"}, 32'(bus.o_valid), 32'd0);
      check({tag, "/o_data"},  32'(bus.o_data),  32'h0000);
      check({tag, "/o_flag"},  32'(bus.o_flag),  32'h0);
      check({tag, "/o_count"}, 32'(bus.o_count), 32'd0);
      check({tag, "/o_busy"},  32'(bus.o_busy),  32'd0);
   endtask

   task automatic run_vec(input string tag, input logic [15:0] exp_data, input logic [3:0] exp_flag,
                          input int exp_cnt, input bit bubbles, input int hold);
      foreach (vec[i]) begin
         if (bubbles && ($urandom_range(0, 3) == 0)) begin
            bus.i_valid = 1'b0;
            @(posedge i_clk); #1;
         end
         bus.i_valid = 1'b1;
         bus.i_data  = vec[i];
         bus.i_last  = (i == vec.size() - 1);
         wait_ready(tag);
         @(posedge i_clk); #1;
      end
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      check({tag, "/valid_latency"}, 32'(bus.o_valid), 32'd1);
      repeat (hold) begin
         @(posedge i_clk); #1;
      end
      check({tag, "/data"},  32'(bus.o_data),  32'(exp_data));
      check({tag, "/flag"},  32'(bus.o_flag),  32'(exp_flag));
      check({tag, "/count"}, 32'(bus.o_count), 32'(exp_cnt));
      check({tag, "/ready_in_done"}, 32'(bus.o_ready), 32'd0);
      bus.i_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.i_ready = 1'b0;
      check({tag, "/valid_after_consume"}, 32'(bus.o_valid), 32'd0);
      check({tag, "/busy_after_consume"},  32'(bus.o_busy),  32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] md;
      logic [3:0]  mf;
      int          mn;

      bus.i_clear = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = 16'h0000;
      bus.i_last  = 1'b0;
      bus.i_ready = 1'b0;
      #12;
      check_reset_values("reset");
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      vec.delete(); vec.push_back(16'h3F80); vec.push_back(16'h4000); vec.push_back(16'h4040);
      run_vec("tp_sum3", 16'h40C0, 4'b0001, 3, 1'b0, 0);

      vec.delete(); vec.push_back(16'h3F80);
      run_vec("tp_single", 16'h3F80, 4'b0001, 1, 1'b0, 1);

      vec.delete(); vec.push_back(16'h3F80); vec.push_back(16'hBF80);
      run_vec("tp_cancel", 16'h0000, 4'b0100, 2, 1'b0, 0);

      vec.delete(); vec.push_back(16'h7F80); vec.push_back(16'hFF80);
      run_vec("tp_inf_nan", 16'hFFC0, INF_NAN_FLAG, 2, 1'b0, 0);

      // Result backpressure with a pending operand held on the input.
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h3F80;
      bus.i_last  = 1'b1;
      @(posedge i_clk); #1;
      bus.i_data  = 16'h4000;
      for (int c = 0; c < 3; c++) begin
         check("bp/o_ready_low", 32'(bus.o_ready), 32'd0);
         check("bp/o_valid_high", 32'(bus.o_valid), 32'd1);
         check("bp/o_data_stable", 32'(bus.o_data), 32'h3F80);
         check("bp/o_count_stable", 32'(bus.o_count), 32'd1);
         @(posedge i_clk); #1;
      end
      bus.i_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.i_ready = 1'b0;
      check("bp/idle_valid", 32'(bus.o_valid), 32'd0);
      check("bp/idle_ready", 32'(bus.o_ready), 32'd1);
      check("bp/idle_busy",  32'(bus.o_busy),  32'd0);
      @(posedge i_clk); #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      check("bp/next_valid", 32'(bus.o_valid), 32'd1);
      check("bp/next_data",  32'(bus.o_data),  32'h4000);
      check("bp/next_count", 32'(bus.o_count), 32'd1);
      bus.i_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.i_ready = 1'b0;

      // Synchronous clear after two of four beats; the coincident beat is discarded.
      bus.i_valid = 1'b1;
      bus.i_last  = 1'b0;
      bus.i_data  = 16'h3F80;
      @(posedge i_clk); #1;
      bus.i_data  = 16'h4000;
      @(posedge i_clk); #1;
      bus.i_clear = 1'b1;
      bus.i_data  = 16'h4040;
      @(posedge i_clk); #1;
      bus.i_clear = 1'b0;
      bus.i_valid = 1'b0;
      check("clear/busy",  32'(bus.o_busy),  32'd0);
      check("clear/count", 32'(bus.o_count), 32'd0);
      check("clear/valid", 32'(bus.o_valid), 32'd0);
      vec.delete(); vec.push_back(16'h4000);
      run_vec("clear_next", 16'h4000, 4'b0001, 1, 1'b0, 0);

      for (int v = 0; v < 60; v++) begin
         vec.delete();
         for (int k = 0; k < $urandom_range(1, 6); k++) vec.push_back(rand_bf16());
         model_vec(md, mf, mn);
         run_vec($sformatf("rand%0d", v), md, mf, mn, 1'b1, $urandom_range(0, 2));
      end

      // Count saturation while accumulation carries on.
      vec.delete();
      for (int k = 0; k < 300; k++)
         vec.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(124, 128)), 7'($urandom)});
      model_vec(md, mf, mn);
      run_vec("saturate", md, mf, mn, 1'b0, 0);

      // Asynchronous reset mid-vector.
      bus.i_valid = 1'b1;
      bus.i_last  = 1'b0;
      bus.i_data  = 16'h3F80;
      repeat (2) begin
         @(posedge i_clk); #1;
      end
      bus.i_valid = 1'b0;
      check("areset/busy_before", 32'(bus.o_busy), 32'd1);
      #3;
      i_rst_n = 1'b0;
      #1;
      check_reset_values("areset");
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      vec.delete(); vec.push_back(16'h3F80);
      run_vec("areset_next", 16'h3F80, 4'b0001, 1, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
